hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined RISC-V core.
- Forwarding: selects among `FWD_SRCS` later-stage forwarding sources.
- Variable-latency hazards: a per-register scoreboard tracks in-flight long-latency ops (loads, mul/div) and stalls ID until their writeback.
- Redirects: on a branch/jump redirect from EX, generates a flush window `FLUSH_CYCLES` long.
- Placement: sits beside the decode stage and replaces the fixed one-cycle load-use check with a latency-independent one.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside decode: EX operand forwarding select,
// a per-register scoreboard for long-latency ops, and a redirect flush window.
module hazard_scoreboard #(
    parameter int REG_W           = 5,
    parameter int FWD_SRCS        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 1,
    localparam int NUM_REGS = 2**REG_W,
    localparam int SW       = $clog2(FWD_SRCS+1),
    localparam int OW       = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_W-1:0]          id_rs1,
    input  logic [REG_W-1:0]          id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_W-1:0]          id_rd,
    input  logic                      id_rd_we,
    input  logic                      id_long,
    input  logic                      wb_valid,
    input  logic [REG_W-1:0]          wb_rd,
    input  logic                      redirect,
    input  logic [REG_W-1:0]          ex_rs1,
    input  logic [REG_W-1:0]          ex_rs2,
    input  logic [FWD_SRCS-1:0]       fwd_we,
    input  logic [FWD_SRCS*REG_W-1:0] fwd_rd,
    output logic [SW-1:0]             fwd_sel_a,
    output logic [SW-1:0]             fwd_sel_b,
    output logic                      stall,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic [NUM_REGS-1:0]       pending,
    output logic [OW-1:0]             outstanding,
    output logic                      sb_err
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OW-1:0]       outstanding_q, outstanding_d;
    logic [FCW-1:0]      flush_cnt_q, flush_cnt_d;
    logic                sb_err_q, sb_err_d;
    logic                haz, flush_act, issue, wb_clear, wb_stray;

    // Walk from the oldest source down so the youngest match is the last write.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        for (int k = FWD_SRCS-1; k >= 0; k--) begin
            if (fwd_we[k] && fwd_rd[k*REG_W +: REG_W] != '0) begin
                if (fwd_rd[k*REG_W +: REG_W] == ex_rs1) fwd_sel_a = SW'(k+1);
                if (fwd_rd[k*REG_W +: REG_W] == ex_rs2) fwd_sel_b = SW'(k+1);
            end
        end
    end

    // Only registered pending is consulted: a same-cycle writeback does not bypass.
    assign haz = id_valid &&
                 ((id_rs1_used && pending_q[id_rs1]) ||
                  (id_rs2_used && pending_q[id_rs2]) ||
                  (id_rd_we    && pending_q[id_rd])  ||
                  (id_long     && outstanding_q == OW'(MAX_OUTSTANDING)));

    assign flush_act = redirect || (flush_cnt_q != '0);
    assign issue     = id_valid && !haz && !flush_act && id_long && id_rd_we && (id_rd != '0);
    assign wb_clear  = wb_valid && (wb_rd != '0) && pending_q[wb_rd];
    assign wb_stray  = wb_valid && (wb_rd != '0) && !pending_q[wb_rd];

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        sb_err_d      = sb_err_q | wb_stray;
        flush_cnt_d   = flush_cnt_q;
        if (wb_clear) pending_d[wb_rd] = 1'b0;
        if (issue)    pending_d[id_rd] = 1'b1;
        pending_d[0] = 1'b0;
        case ({issue, wb_clear})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect)
            flush_cnt_d = FCW'(FLUSH_CYCLES-1);
        else if (flush_cnt_q != '0)
            flush_cnt_d = flush_cnt_q - FCW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            flush_cnt_q   <= '0;
            sb_err_q      <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            flush_cnt_q   <= flush_cnt_d;
            sb_err_q      <= sb_err_d;
        end
    end

    // A redirect outranks a hazard: the stalled instruction is being squashed anyway.
    always_comb begin
        stall       = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (flush_act) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (haz) begin
            stall       = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;
    assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard; expectations come from a
// register-array reference model and are checked by a negedge monitor.
module tb_hazard_scoreboard;

    localparam int FC = 3;
    localparam int MAXO = 4;

    typedef struct packed {
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic        stall;
        logic        ifid;
        logic        idex;
        logic [31:0] pend;
        logic [2:0]  outs;
        logic        err;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic        clk, rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd, ex_rs1, ex_rs2;
    logic        wb_valid, redirect;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall, if_id_flush, id_ex_flush, sb_err;
    logic [31:0] pending;
    logic [2:0]  outstanding;

    hazard_scoreboard #(.REG_W(5), .FWD_SRCS(2), .MAX_OUTSTANDING(MAXO), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_long(id_long), .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect(redirect),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pending(pending), .outstanding(outstanding), .sb_err(sb_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend[32];
    int m_cyc;
    int m_flush_until;
    bit m_err;
    bit check_en;

    logic [EXP_W-1:0] exp_q[$];
    int               cyc_q[$];
    int               n_chk, n_pass;

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) if (m_pend[r]) c++;
        return c;
    endfunction

    function automatic logic [1:0] ref_sel(logic [4:0] src, logic [1:0] we, logic [9:0] rd);
        for (int k = 0; k < 2; k++)
            if (src != 5'd0 && we[k] && rd[k*5 +: 5] == src) return 2'(k+1);
        return 2'd0;
    endfunction

    function automatic bit ref_haz();
        return id_valid && ((id_rs1_used && m_pend[id_rs1]) ||
                            (id_rs2_used && m_pend[id_rs2]) ||
                            (id_rd_we && m_pend[id_rd]) ||
                            (id_long && m_count() == MAXO));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        exp_t e;
        bit   flush, haz, iss;
        flush = redirect || (m_cyc <= m_flush_until);
        haz   = ref_haz();
        if (check_en) begin
            e.sel_a = ref_sel(ex_rs1, fwd_we, fwd_rd);
            e.sel_b = ref_sel(ex_rs2, fwd_we, fwd_rd);
            e.stall = !flush && haz;
            e.ifid  = flush;
            e.idex  = flush || haz;
            for (int r = 0; r < 32; r++) e.pend[r] = m_pend[r];
            e.outs  = 3'(m_count());
            e.err   = m_err;
            exp_q.push_back(EXP_W'(e));
            cyc_q.push_back(m_cyc);
        end
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
            m_flush_until = -1;
            m_err = 1'b0;
        end else begin
            iss = id_valid && !haz && !flush && id_long && id_rd_we && id_rd != 5'd0;
            if (wb_valid && wb_rd != 5'd0) begin
                if (m_pend[wb_rd]) m_pend[wb_rd] = 1'b0;
                else m_err = 1'b1;
            end
            if (iss) m_pend[id_rd] = 1'b1;
            if (redirect) m_flush_until = m_cyc + FC - 1;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; id_long = 0; wb_valid = 0; wb_rd = 0; redirect = 0;
        ex_rs1 = 0; ex_rs2 = 0; fwd_we = 0; fwd_rd = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        id_valid = 1; id_long = 1; id_rd_we = 1; id_rd = rd;
        step();
    endtask

    task automatic writeback(input logic [4:0] rd);
        idle();
        wb_valid = 1; wb_rd = rd;
        step();
    endtask

    task automatic drain();
        for (int r = 1; r < 32; r++) if (m_pend[r]) writeback(5'(r));
        idle();
    endtask

    task automatic random_cycle();
        int list[$];
        id_valid    = ($urandom_range(0, 3) != 0);
        id_rs1      = 5'($urandom_range(0, 7));
        id_rs2      = 5'($urandom_range(0, 7));
        id_rs1_used = 1'($urandom_range(0, 1));
        id_rs2_used = 1'($urandom_range(0, 1));
        id_rd       = 5'($urandom_range(0, 7));
        id_rd_we    = ($urandom_range(0, 3) != 0);
        id_long     = ($urandom_range(0, 2) == 0);
        redirect    = ($urandom_range(0, 9) == 0);
        ex_rs1      = 5'($urandom_range(0, 7));
        ex_rs2      = 5'($urandom_range(0, 7));
        fwd_we      = 2'($urandom_range(0, 3));
        fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        for (int r = 1; r < 32; r++) if (m_pend[r]) list.push_back(r);
        wb_valid = 0;
        wb_rd    = 5'($urandom_range(0, 7));
        if (list.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1;
            wb_rd    = 5'(list[$urandom_range(0, list.size()-1)]);
        end
        step();
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            c = cyc_q.pop_front();
            chk("fwd_sel_a",   c, 64'(fwd_sel_a),   64'(e.sel_a));
            chk("fwd_sel_b",   c, 64'(fwd_sel_b),   64'(e.sel_b));
            chk("stall",       c, 64'(stall),       64'(e.stall));
            chk("if_id_flush", c, 64'(if_id_flush), 64'(e.ifid));
            chk("id_ex_flush", c, 64'(id_ex_flush), 64'(e.idex));
            chk("pending",     c, 64'(pending),     64'(e.pend));
            chk("outstanding", c, 64'(outstanding), 64'(e.outs));
            chk("sb_err",      c, 64'(sb_err),      64'(e.err));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_chk = 0; n_pass = 0; m_cyc = 0; m_flush_until = -1; m_err = 0; check_en = 0;
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        check_en = 1;
        step();

        // forwarding priority and x0
        ex_rs1 = 5; ex_rs2 = 6; fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5};
        step();
        fwd_rd = {5'd5, 5'd0};
        step();
        ex_rs1 = 0; fwd_rd = {5'd6, 5'd0};
        step();

        // variable-latency load on x7, writeback four cycles later
        issue_long(7);
        idle();
        id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
        step(); step(); step();
        wb_valid = 1; wb_rd = 7;
        step();
        wb_valid = 0;
        step();

        // capacity: four in flight, fifth waits for a slot
        issue_long(1); issue_long(2); issue_long(3); issue_long(4);
        idle();
        id_valid = 1; id_long = 1; id_rd_we = 1; id_rd = 9;
        step();
        wb_valid = 1; wb_rd = 2;
        step();
        wb_valid = 0;
        step();
        drain();

        // flush window with a hazard present, restarted by a second redirect
        issue_long(12);
        idle();
        id_valid = 1; id_rs2 = 12; id_rs2_used = 1; redirect = 1;
        step();
        step();
        redirect = 0;
        step(); step(); step();
        wb_valid = 1; wb_rd = 12;
        step();
        idle();
        step();

        for (int i = 0; i < 300; i++) random_cycle();
        drain();

        // stray writeback is sticky and leaves the count alone
        issue_long(5);
        writeback(3);
        idle();
        step(); step();
        writeback(5);

        // reset in the middle of traffic
        issue_long(4);
        issue_long(6);
        idle();
        redirect = 1;
        step();
        redirect = 0; rst_n = 0;
        step();
        rst_n = 1;
        id_valid = 1; id_rs1 = 4; id_rs1_used = 1;
        step();
        idle();
        step();

        @(negedge clk);
        #1;
        chk("queue_drained", m_cyc, 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
